conv_acc_requant: RTL and testbench
===================================

Name: conv_acc_requant

Overview:
Downstream stage of the ternary adder tree that sums the 27 signed products of one 3x3x3 convolution window.
- Tracks issued windows through the tree's fixed pipeline latency, since the tree carries no valid signal.
- Accumulates partial sums over several input-channel groups, then applies bias, optional ReLU, rounding right-shift and saturation.
- Buffers results in a small FIFO with ready/valid output and issues credit back to the window issuer.

Parameters:
WIDTH_SUM, 20, width of signed tree_sum input
WIDTH_ACC, 28, width of signed accumulator and bias
WIDTH_OUT, 8, width of signed output activation
SHIFT_W, 5, width of shift amount
TREE_LAT, 3, cycles from issue to tree_sum valid (pipelined 27-input tree)
FIFO_DEPTH, 4, output FIFO entries (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
issue_valid  in  1  window presented to adder tree this cycle
issue_last  in  1  qualifies issue_valid: final channel group of one output
issue_ok  out  1  issuer may assert issue_valid with issue_last
tree_sum  in  WIDTH_SUM  signed adder-tree result
bias  in  WIDTH_ACC  signed bias; static while issues are in flight
shift  in  SHIFT_W  requant right-shift; static while issues are in flight
relu_en  in  1  enable ReLU; static while issues are in flight
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  WIDTH_OUT  signed activation
sat_flag  out  1  sticky: a result saturated
err_flag  out  1  sticky: last-issue accepted without credit

Behaviour:
- Reset: all outputs 0, except issue_ok, which is 1 on the first cycle after reset.
- Reset clears the delay line, accumulator, first flag (to 1), in-flight count, FIFO and sticky flags. Tree results still in flight are ignored after reset.
- Delay line: TREE_LAT-deep shift registers of issue_valid and issue_last. The arrival cycle is a = issue cycle + TREE_LAT; tree_sum is sampled only when the delayed valid is 1.
- Accumulate at end of cycle a:
  - acc <= (first ? bias : acc) + sext(tree_sum).
  - If delayed last: first <= 1, fin_valid <= 1, fin <= new acc value.
  - Otherwise: first <= 0.
  - Back-to-back arrivals are supported, one per cycle.
- Requant at end of a+1 when fin_valid, then write to FIFO:
  - If relu_en and fin<0, the value is 0.
  - If shift>0, add 2^(shift-1), then arithmetic shift right (round half toward +inf).
  - Saturate to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1]; any clip sets sat_flag.
- Latency: issue_last to out_valid is TREE_LAT+2 cycles when the FIFO is empty. FIFO read is first-word-fall-through; pop on out_valid and out_ready.
- Credit:
  - inflight increments on accepted issue_valid & issue_last and decrements on FIFO write. Simultaneous increment and decrement leave it unchanged.
  - issue_ok = (fifo_count + inflight) < FIFO_DEPTH, computed from registers only, with no combinational path from out_ready.
  - A pop frees credit visible in the next cycle.
  - Non-last issues need no credit.
- Protocol violation: issue_valid & issue_last while issue_ok=0 sets err_flag. The corresponding FIFO write, if the FIFO is full, is dropped; inflight still decrements.
- FIFO full and empty are never simultaneously written and read illegally. Simultaneous push and pop when full is impossible by credit; simultaneous push and pop when empty is a push only.
- Widths: sign-extend tree_sum to WIDTH_ACC. The accumulator wraps; WIDTH_ACC is sized by the integrator so it cannot overflow.

Decomposition:
- Shared package conv_pkg holds:
  - width localparams: WIDTH_SUM, WIDTH_ACC, WIDTH_OUT, SHIFT_W;
  - pure function requant(acc, shift, relu_en), returning a saturated value plus a sat bit, reused by the reference model.
- One sub-module: sync_fifo (parameterized WIDTH, DEPTH, first-word-fall-through, count output, same clk/rst_n).

Test Plan:
1. Single group, no rounding: bias=10, shift=0, relu_en=0; issue_valid=issue_last=1 at cycle 0; tree_sum=5 at cycle 3 -> out_valid=1, out_data=15 at cycle 5.
2. Three groups with rounding: bias=8, shift=2; tree_sum=100,200,-50 on consecutive arrivals (last on the third) -> acc 258 -> out_data=65.
3. ReLU: bias=-100, tree_sum=20, relu_en=1 -> out_data=0. The same stimulus with relu_en=0 -> out_data=-80 (0xB0).
4. Saturation:
   - acc=1000, shift=0 -> out_data=127, sat_flag=1.
   - acc=-1000 -> out_data=-128.
   - After reset -> sat_flag=0.
5. Backpressure, FIFO_DEPTH=4: out_ready=0; issuer sends single-group lasts gated by issue_ok -> exactly 4 accepted, then issue_ok=0. Raise out_ready -> 4 results pop in order; issue_ok=1 one cycle after the first pop; err_flag stays 0.
6. Reset mid-flight: issue at cycle 0; rst_n=0 at cycle 1 -> no out_valid ever, issue_ok=1 after reset, tree_sum at cycle 3 ignored.

Source files
------------

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths and requantisation helper for conv_acc_requant
package conv_pkg;

  localparam int WIDTH_SUM = 20;
  localparam int WIDTH_ACC = 28;
  localparam int WIDTH_OUT = 8;
  localparam int SHIFT_W   = 5;

  // Wide enough that the rounding constant for any shift amount cannot overflow.
  localparam int EXT_W = WIDTH_ACC + 2**SHIFT_W;

  localparam logic signed [EXT_W-1:0] OMAX = EXT_W'(2**(WIDTH_OUT-1) - 1);
  localparam logic signed [EXT_W-1:0] OMIN = -(EXT_W'(2**(WIDTH_OUT-1)));

  typedef struct packed {
    logic                 sat;
    logic [WIDTH_OUT-1:0] data;
  } rq_t;

  function automatic rq_t requant(input logic signed [WIDTH_ACC-1:0] acc,
                                  input logic [SHIFT_W-1:0] shift,
                                  input logic relu_en);
    logic signed [EXT_W-1:0] v;
    logic signed [EXT_W-1:0] rnd;
    logic signed [EXT_W-1:0] r;
    rq_t res;
    if (relu_en && (acc < 0)) begin
      v = '0;
    end else begin
      v = EXT_W'(acc);
    end
    rnd = '0;
    if (shift != '0) begin
      rnd = EXT_W'(1) << (shift - 1'b1);
    end
    r = (v + rnd) >>> shift;
    if (r > OMAX) begin
      res.data = OMAX[WIDTH_OUT-1:0];
      res.sat  = 1'b1;
    end else if (r < OMIN) begin
      res.data = OMIN[WIDTH_OUT-1:0];
      res.sat  = 1'b1;
    end else begin
      res.data = r[WIDTH_OUT-1:0];
      res.sat  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A push into a full FIFO is discarded; a pop of an empty FIFO does nothing.
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      end
      count <= count + CW'(wr_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/conv_acc_requant.sv
// rtl/conv_acc_requant.sv - adder-tree result accumulation, requantisation and credit-gated output FIFO
module conv_acc_requant
  import conv_pkg::*;
#(
  parameter int TREE_LAT   = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic                 issue_last,
  output logic                 issue_ok,
  input  logic [WIDTH_SUM-1:0] tree_sum,
  input  logic [WIDTH_ACC-1:0] bias,
  input  logic [SHIFT_W-1:0]   shift,
  input  logic                 relu_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_OUT-1:0] out_data,
  output logic                 sat_flag,
  output logic                 err_flag
);

  localparam int CW = $clog2(FIFO_DEPTH+1);
  // Every last issue reaches the FIFO write within TREE_LAT+1 cycles, bounding inflight.
  localparam int IW = $clog2(TREE_LAT+3);

  logic [TREE_LAT-1:0]         vld_d;
  logic [TREE_LAT-1:0]         last_d;
  logic                        arr_valid;
  logic                        arr_last;
  logic signed [WIDTH_ACC-1:0] sum_ext;
  logic signed [WIDTH_ACC-1:0] acc_base;
  logic signed [WIDTH_ACC-1:0] acc_next;
  logic signed [WIDTH_ACC-1:0] acc;
  logic signed [WIDTH_ACC-1:0] fin;
  logic                        first;
  logic                        fin_valid;
  logic [IW-1:0]               inflight;
  logic [CW-1:0]               fifo_count;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic                        push;
  logic                        last_issue;
  rq_t                         rq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_d  <= '0;
      last_d <= '0;
    end else begin
      vld_d[0]  <= issue_valid;
      last_d[0] <= issue_valid & issue_last;
      for (int i = 1; i < TREE_LAT; i++) begin
        vld_d[i]  <= vld_d[i-1];
        last_d[i] <= last_d[i-1];
      end
    end
  end

  assign arr_valid = vld_d[TREE_LAT-1];
  assign arr_last  = last_d[TREE_LAT-1];
  assign sum_ext   = {{(WIDTH_ACC-WIDTH_SUM){tree_sum[WIDTH_SUM-1]}}, tree_sum};

  always_comb begin
    acc_base = first ? $signed(bias) : acc;
    acc_next = acc_base + sum_ext;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      fin       <= '0;
      first     <= 1'b1;
      fin_valid <= 1'b0;
    end else begin
      fin_valid <= arr_valid & arr_last;
      if (arr_valid) begin
        acc <= acc_next;
        if (arr_last) begin
          first <= 1'b1;
          fin   <= acc_next;
        end else begin
          first <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rq = requant(fin, shift, relu_en);
  end

  // Only a protocol violation can present a result to a full FIFO; it is dropped.
  assign push       = fin_valid & ~fifo_full;
  assign last_issue = issue_valid & issue_last;
  assign issue_ok   = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);
  assign out_valid  = ~fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight <= '0;
      sat_flag <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      inflight <= inflight + IW'(last_issue) - IW'(fin_valid);
      if (fin_valid && rq.sat) begin
        sat_flag <= 1'b1;
      end
      if (last_issue && !issue_ok) begin
        err_flag <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (WIDTH_OUT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (rq.data),
    .pop       (out_ready),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_conv_acc_requant.sv
// tb/tb_conv_acc_requant.sv - scoreboard bench for conv_acc_requant
module tb_conv_acc_requant;
  import conv_pkg::*;

  localparam int TREE_LAT = 3;
  localparam int FIFO_DEPTH = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 issue_valid;
  logic                 issue_last;
  logic                 issue_ok;
  logic [WIDTH_SUM-1:0] tree_sum;
  logic [WIDTH_ACC-1:0] bias;
  logic [SHIFT_W-1:0]   shift;
  logic                 relu_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_OUT-1:0] out_data;
  logic                 sat_flag;
  logic                 err_flag;

  conv_acc_requant #(.TREE_LAT(TREE_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_last(issue_last),
    .issue_ok(issue_ok), .tree_sum(tree_sum), .bias(bias), .shift(shift),
    .relu_en(relu_en), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .sat_flag(sat_flag), .err_flag(err_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int obs_valid = 0;

  // Environment model of the adder tree: a value issued now shows up TREE_LAT cycles later.
  int pipe_sum[TREE_LAT];
  bit pipe_v[TREE_LAT];

  longint m_acc = 0;
  longint m_bias = 0;
  int     m_shift = 0;
  bit     m_relu = 0;
  bit     m_first = 1;
  bit     m_sat = 0;
  bit     rand_rdy = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void ref_rq(input longint a, output int val, output bit sat);
    longint v;
    longint hi;
    longint lo;
    hi = 2**(WIDTH_OUT-1) - 1;
    lo = -(2**(WIDTH_OUT-1));
    v = (m_relu && a < 0) ? 0 : a;
    if (m_shift > 0) v = (v + (longint'(1) << (m_shift - 1))) >>> m_shift;
    sat = 1'b0;
    if (v > hi) begin val = int'(hi); sat = 1'b1; end
    else if (v < lo) begin val = int'(lo); sat = 1'b1; end
    else val = int'(v);
  endfunction

  // kind: 0 expect model value, 1 expect literal, 2 expect nothing
  task automatic step(input bit v, input bit l, input int s, input int kind, input int lit);
    int val;
    bit sat;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    issue_valid = v;
    issue_last = l;
    if (v) begin
      m_acc = (m_first ? m_bias : m_acc) + s;
      if (l) begin
        m_first = 1'b1;
        ref_rq(m_acc, val, sat);
        if (kind != 2) m_sat |= sat;
        if (kind == 0) exp_q.push_back(val);
        if (kind == 1) exp_q.push_back(lit);
      end else begin
        m_first = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    for (int i = TREE_LAT - 1; i > 0; i--) begin
      pipe_v[i] = pipe_v[i-1];
      pipe_sum[i] = pipe_sum[i-1];
    end
    pipe_v[0] = v;
    pipe_sum[0] = s;
    tree_sum = pipe_v[TREE_LAT-1] ? WIDTH_SUM'(pipe_sum[TREE_LAT-1]) : WIDTH_SUM'($urandom);
    issue_valid = 1'b0;
    issue_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2, 0);
  endtask

  task automatic cfg(input longint b, input int sh, input bit r);
    m_bias = b;
    m_shift = sh;
    m_relu = r;
    bias = b[WIDTH_ACC-1:0];
    shift = SHIFT_W'(sh);
    relu_en = r;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    m_first = 1'b1;
    m_acc = 0;
    m_sat = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    int n;
    bit save;
    save = rand_rdy;
    rand_rdy = 0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      idle(1);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    rand_rdy = save;
  endtask

  task automatic issue_gated(input int s);
    int n;
    n = 0;
    while (!issue_ok && n < 100) begin
      idle(1);
      n++;
    end
    if (!issue_ok) check("issue_ok_timeout", 0, 1);
    else step(1, 1, s, 0, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) obs_valid++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("out_unexpected", longint'($signed(out_data)), 9999);
      else check("out_data", longint'($signed(out_data)), exp_q.pop_front());
    end
  end

  initial begin
    int accepted;
    int grp;
    rst_n = 1'b0;
    issue_valid = 1'b0;
    issue_last = 1'b0;
    tree_sum = '0;
    out_ready = 1'b0;
    cfg(0, 0, 0);
    for (int i = 0; i < TREE_LAT; i++) begin pipe_v[i] = 0; pipe_sum[i] = 0; end
    @(posedge clk); #1;
    do_reset();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_sat", sat_flag, 0);
    check("rst_err", err_flag, 0);
    check("rst_issue_ok", issue_ok, 1);

    // single group, exact latency
    cfg(10, 0, 0);
    out_ready = 1'b1;
    step(1, 1, 5, 1, 15);
    idle(3);
    check("lat_cycle4_valid", out_valid, 0);
    idle(1);
    check("lat_cycle5_valid", out_valid, 1);
    drain();

    // three groups with rounding
    cfg(8, 2, 0);
    step(1, 0, 100, 2, 0);
    step(1, 0, 200, 2, 0);
    step(1, 1, -50, 1, 65);
    drain();

    // relu on and off
    cfg(-100, 0, 1);
    step(1, 1, 20, 1, 0);
    drain();
    cfg(-100, 0, 0);
    step(1, 1, 20, 1, -80);
    drain();
    check("sat_before", sat_flag, 0);

    // saturation
    cfg(990, 0, 0);
    step(1, 1, 10, 1, 127);
    drain();
    check("sat_hi", sat_flag, 1);
    cfg(-990, 0, 0);
    step(1, 1, -10, 1, -128);
    drain();
    do_reset();
    check("sat_after_reset", sat_flag, 0);

    // backpressure and credit
    cfg(0, 0, 0);
    out_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 12; i++) begin
      if (issue_ok) begin
        step(1, 1, int'($urandom_range(0, 200)) - 100, 0, 0);
        accepted++;
      end else begin
        idle(1);
      end
    end
    check("bp_accepted", accepted, FIFO_DEPTH);
    check("bp_issue_ok_low", issue_ok, 0);
    out_ready = 1'b1;
    #1;
    check("bp_no_comb_ready", issue_ok, 0);
    idle(1);
    check("bp_ok_after_pop", issue_ok, 1);
    drain();
    check("bp_err", err_flag, 0);

    // protocol violation with full FIFO: write dropped, credit recovers
    out_ready = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) step(1, 1, 30 + i, 0, 0);
    idle(2);
    check("viol_ok_low", issue_ok, 0);
    step(1, 1, 7, 2, 0);
    idle(TREE_LAT + 3);
    check("viol_err", err_flag, 1);
    drain();
    check("viol_ok_recover", issue_ok, 1);
    do_reset();
    check("err_after_reset", err_flag, 0);

    // reset while a result is in flight
    obs_valid = 0;
    out_ready = 1'b1;
    cfg(50, 0, 0);
    step(1, 1, 33, 2, 0);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    m_first = 1'b1;
    m_sat = 1'b0;
    exp_q.delete();
    idle(8);
    check("midrst_no_valid", obs_valid, 0);
    check("midrst_issue_ok", issue_ok, 1);

    // randomized batches against the reference model
    for (int b = 0; b < 8; b++) begin
      cfg(longint'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
      rand_rdy = 1;
      for (int o = 0; o < 25; o++) begin
        grp = int'($urandom_range(1, 4));
        for (int g = 0; g < grp - 1; g++) begin
          if ($urandom_range(0, 3) == 0) idle(1);
          step(1, 0, int'($urandom_range(0, 10000)) - 5000, 2, 0);
        end
        issue_gated(int'($urandom_range(0, 10000)) - 5000);
      end
      rand_rdy = 0;
      drain();
      check("rand_sat", sat_flag, m_sat);
      check("rand_err", err_flag, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
